fetch_queue: RTL and testbench

Front-end fetch stage of the Tomasulo core. Reads 16-bit instructions from the 16-entry instruction memory at `pc`, buffers them in a 4-entry circular instruction queue, and presents the oldest entry to the issue stage over a valid/ready handshake. It also handles halt detection and redirect flushes.

---
 rtl/tomasulo_pkg.sv | 20 ++
 rtl/iq_fifo.sv | 45 ++++
 rtl/fetch_queue.sv | 73 +++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared constants and types for the Tomasulo core front end
package tomasulo_pkg;
  localparam int IQ_DEPTH = 4;
  localparam int PC_W = 4;
  localparam int INSTR_W = 16;
  localparam logic [3:0] OP_SUB = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_ST = 4'h4;
  localparam logic [3:0] OP_LD = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;
  typedef enum logic {ST_RUN, ST_HALT} fetch_state_e;
endpackage

// File: rtl/iq_fifo.sv
// iq_fifo: circular FIFO with push/pop, occupancy count and synchronous clear
module iq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  // pointer and occupancy update; clear wins over any push or pop
  always_comb begin
    head_d = clr ? '0 : head_q + AW'(pop);
    tail_d = clr ? '0 : tail_q + AW'(push);
    count_d = clr ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // entry storage needs no reset: it is only read while count is nonzero
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[tail_q] <= din;
  end
  assign dout = mem_q[head_q];
  assign count = count_q;
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: pc sequencing, halt detection and redirect flush in front of the instruction queue
module fetch_queue #(
  parameter int IQ_DEPTH = tomasulo_pkg::IQ_DEPTH,
  parameter int INSTR_W = tomasulo_pkg::INSTR_W,
  parameter int PC_W = tomasulo_pkg::PC_W,
  parameter logic [3:0] HALT_OP = tomasulo_pkg::OP_HALT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [PC_W-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]          imem_data,
  input  logic                        flush,
  input  logic [PC_W-1:0]             flush_pc,
  input  logic                        deq_ready,
  output logic                        deq_valid,
  output logic [INSTR_W-1:0]          deq_instr,
  output logic [PC_W-1:0]             deq_pc,
  output logic [$clog2(IQ_DEPTH):0]   iq_count,
  output logic                        iq_full,
  output logic                        fetch_done
);
  import tomasulo_pkg::*;
  localparam int CW = $clog2(IQ_DEPTH) + 1;
  localparam logic [PC_W-1:0] PC_MAX = '1;
  fetch_state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CW-1:0] count;
  logic [INSTR_W+PC_W-1:0] head;
  logic deq, fetch, is_halt, enq;
  assign deq_valid = count != '0;
  assign deq = deq_valid & deq_ready;
  assign is_halt = imem_data[INSTR_W-1 -: 4] == HALT_OP;
  assign fetch = state_q == ST_RUN && !flush && (count < CW'(IQ_DEPTH) || deq);
  assign enq = fetch & !is_halt;
  // next pc and run/halt state; the last address halts instead of wrapping
  always_comb begin
    pc_d = pc_q;
    state_d = state_q;
    if (flush) begin
      pc_d = flush_pc;
      state_d = ST_RUN;
    end else if (fetch) begin
      state_d = (is_halt || pc_q == PC_MAX) ? ST_HALT : ST_RUN;
      pc_d = (enq && pc_q != PC_MAX) ? pc_q + 1'b1 : pc_q;
    end
  end
  // pc and FSM registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
    end
  end
  iq_fifo #(.DEPTH(IQ_DEPTH), .W(INSTR_W + PC_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(enq),
    .pop(deq),
    .din({imem_data, pc_q}),
    .dout(head),
    .count(count)
  );
  assign imem_addr = pc_q;
  assign deq_instr = deq_valid ? head[PC_W +: INSTR_W] : '0;
  assign deq_pc = deq_valid ? head[PC_W-1:0] : '0;
  assign iq_count = count;
  assign iq_full = count == CW'(IQ_DEPTH);
  assign fetch_done = state_q == ST_HALT;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector tables, pc sweep and randomized run against a queue-based model
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [3:0] flush_pc = '0;
  logic deq_ready = 1'b0;
  logic [3:0] imem_addr;
  logic [15:0] imem_data;
  logic deq_valid;
  logic [15:0] deq_instr;
  logic [3:0] deq_pc;
  logic [2:0] iq_count;
  logic iq_full;
  logic fetch_done;
  logic [15:0] mem [16];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic r, f;
    logic [3:0] fp;
    logic rdy;
    logic v;
    logic [15:0] ins;
    logic [3:0] p;
    logic [2:0] c;
    logic fu, dn;
    logic [3:0] ad;
  } vec_t;
  typedef struct packed {
    logic [15:0] ins;
    logic [3:0] p;
  } ent_t;

  ent_t mq[$];
  int mpc;
  bit mhalt;
  vec_t ta[6];
  vec_t tbv[19];

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .flush(flush), .flush_pc(flush_pc), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
    .iq_count(iq_count), .iq_full(iq_full), .fetch_done(fetch_done)
  );

  task automatic step(input logic r, input logic f, input logic [3:0] fp, input logic rdy);
    rst_n = r;
    flush = f;
    flush_pc = fp;
    deq_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input logic v, input logic [15:0] ins, input logic [3:0] p,
                     input logic [2:0] c, input logic fu, input logic dn, input logic [3:0] ad);
    vectors++;
    if ({deq_valid, deq_instr, deq_pc, iq_count, iq_full, fetch_done, imem_addr} !== {v, ins, p, c, fu, dn, ad}) begin
      miscompares++;
      $display("FAIL %s: got v=%0b instr=%h pc=%0d cnt=%0d full=%0b done=%0b addr=%0d, want v=%0b instr=%h pc=%0d cnt=%0d full=%0b done=%0b addr=%0d",
               nm, deq_valid, deq_instr, deq_pc, iq_count, iq_full, fetch_done, imem_addr,
               v, ins, p, c, fu, dn, ad);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t t);
    step(t.r, t.f, t.fp, t.rdy);
    cmp(nm, t.v, t.ins, t.p, t.c, t.fu, t.dn, t.ad);
  endtask

  // reference: entries move through a plain queue; dequeue frees room before the fetch decision
  task automatic model_edge(input logic r, input logic f, input logic [3:0] fp, input logic rdy);
    if (!r) begin
      mq.delete();
      mpc = 0;
      mhalt = 0;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (f) begin
        mq.delete();
        mpc = fp;
        mhalt = 0;
      end else if (!mhalt && mq.size() < 4) begin
        if (mem[mpc][15:12] == 4'hF) mhalt = 1;
        else begin
          mq.push_back(ent_t'{ins: mem[mpc], p: 4'(mpc)});
          if (mpc == 15) mhalt = 1;
          else mpc++;
        end
      end
    end
  endtask

  task automatic cmp_model(input string nm);
    logic v;
    v = mq.size() != 0;
    cmp(nm, v, v ? mq[0].ins : 16'h0, v ? mq[0].p : 4'h0, 3'(mq.size()),
        mq.size() == 4, mhalt, 4'(mpc));
  endtask

  initial begin
    ta[0] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0};
    ta[1] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 16'h1123, 4'd0, 3'd1, 1'b0, 1'b0, 4'd1};
    ta[2] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 16'h2456, 4'd1, 3'd1, 1'b0, 1'b0, 4'd2};
    ta[3] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 16'h3789, 4'd2, 3'd1, 1'b0, 1'b0, 4'd3};
    ta[4] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b1, 4'd3};
    ta[5] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b1, 4'd3};

    tbv[0]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b0, 4'd0};
    tbv[1]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd1, 1'b0, 1'b0, 4'd1};
    tbv[2]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd2, 1'b0, 1'b0, 4'd2};
    tbv[3]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd3, 1'b0, 1'b0, 4'd3};
    tbv[4]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd4, 1'b1, 1'b0, 4'd4};
    tbv[5]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd4, 1'b1, 1'b0, 4'd4};
    tbv[6]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 16'h1001, 4'd1,  3'd4, 1'b1, 1'b0, 4'd5};
    tbv[7]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 16'h1002, 4'd2,  3'd4, 1'b1, 1'b0, 4'd6};
    tbv[8]  = '{1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b0, 4'd9};
    tbv[9]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1009, 4'd9,  3'd1, 1'b0, 1'b0, 4'd10};
    tbv[10] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b0, 4'd15};
    tbv[11] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h100F, 4'd15, 3'd1, 1'b0, 1'b1, 4'd15};
    tbv[12] = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b1, 4'd15};
    tbv[13] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b1, 4'd15};
    tbv[14] = '{1'b1, 1'b1, 4'd2,  1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b0, 4'd2};
    tbv[15] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1002, 4'd2,  3'd1, 1'b0, 1'b0, 4'd3};
    tbv[16] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1002, 4'd2,  3'd2, 1'b0, 1'b0, 4'd4};
    tbv[17] = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 16'h0000, 4'd0,  3'd0, 1'b0, 1'b0, 4'd0};
    tbv[18] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 16'h1000, 4'd0,  3'd1, 1'b0, 1'b0, 4'd1};

    for (int i = 0; i < 16; i++) mem[i] = 16'h1000;
    mem[0] = 16'h1123;
    mem[1] = 16'h2456;
    mem[2] = 16'h3789;
    mem[3] = 16'hF000;
    for (int i = 0; i < 6; i++) run_vec($sformatf("halt_seq[%0d]", i), ta[i]);

    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 19; i++) run_vec($sformatf("fill_flush[%0d]", i), tbv[i]);

    step(1'b0, 1'b0, 4'd0, 1'b1);
    cmp("sweep_reset", 1'b0, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      cmp($sformatf("sweep[%0d]", i), 1'b1, 16'h1000 + 16'(i), 4'(i), 3'd1, 1'b0,
          i == 15, i == 15 ? 4'd15 : 4'(i + 1));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b1);
      cmp("sweep_nowrap", 1'b0, 16'h0, 4'd0, 3'd0, 1'b0, 1'b1, 4'd15);
    end

    for (int k = 0; k < 3000; k++) begin
      logic r, f, rdy;
      logic [3:0] fp;
      if (k % 200 == 0)
        for (int i = 0; i < 16; i++)
          mem[i] = {($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5)), 12'($urandom)};
      r = (k == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
      f = $urandom_range(0, 15) == 0;
      fp = 4'($urandom);
      rdy = $urandom_range(0, 3) != 0;
      model_edge(r, f, fp, rdy);
      step(r, f, fp, rdy);
      cmp_model($sformatf("rand[%0d]", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
